// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the routing-node phase sequencer: state encoding,
// default word width and the node pipeline phase indices.
package phase_sequencer_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_FINISH = ST_FINISH
    } seq_state_t;

    // Phase order of the routing-node pipeline (index = launch order).
    typedef enum logic [2:0] {
        LEARN_COSTS     = 3'd0,
        UPDATE_TABLE    = 3'd1,
        COLLECT_STATS   = 3'd2,
        FOR_AGGREGATION = 3'd3,
        COMPUTE_ROUTES  = 3'd4,
        EVAL_POLICY     = 3'd5,
        RANK_ACTIONS    = 3'd6,
        SELECT_ACTION   = 3'd7
    } node_phase_t;

endpackage

// File: rtl/phase_next_sel.sv
// Next-phase picker: lowest set mask bit strictly above cur.
// cur is two's complement on SEL_WIDTH+1 bits so that all-ones (-1)
// selects the lowest set bit of the whole mask (first phase of a run).
module phase_next_sel #(
    parameter int NUM_PHASES = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] mask,
    input  logic [SEL_WIDTH:0]    cur,
    output logic [SEL_WIDTH-1:0]  next_idx,
    output logic                  next_vld
);

    logic [SEL_WIDTH:0] lo;

    assign lo = cur + {{SEL_WIDTH{1'b0}}, 1'b1};

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        next_idx = '0;
        next_vld = 1'b0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(lo))) begin
                next_idx = SEL_WIDTH'(i);
                next_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer and shared memory port arbiter for the routing node.
// Launches the masked client phases in index order with start/done
// handshakes, ends early on a client abort, and routes the active client
// onto the single memory port.
// Optional: `define PHASE_WATCHDOG_EN adds a per-phase WAIT watchdog and a
// sticky timeout output.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = WORD_WIDTH,
    parameter int SEL_WIDTH      = $clog2(NUM_PHASES),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                             clock,
    input  logic                             nrst,
    input  logic                             en,
    input  logic [NUM_PHASES-1:0]            phase_mask,
    output logic [NUM_PHASES-1:0]            phase_start,
    input  logic [NUM_PHASES-1:0]            phase_done,
    input  logic [NUM_PHASES-1:0]            phase_abort,
    input  logic [NUM_PHASES*ADDR_WIDTH-1:0] phase_addr,
    input  logic [NUM_PHASES-1:0]            phase_wr_en,
    input  logic [NUM_PHASES*DATA_WIDTH-1:0] phase_wdata,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             mem_wr_en,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [SEL_WIDTH-1:0]             active_phase,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic [SEL_WIDTH-1:0]             abort_phase
`ifdef PHASE_WATCHDOG_EN
    ,
    output logic                             timeout
`endif
);

    // Elaboration-time guard on the supported configuration range.
    if (NUM_PHASES < 2 || NUM_PHASES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("phase_sequencer: NUM_PHASES must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    seq_state_t                state_q, state_d;
    logic [NUM_PHASES-1:0]     mask_q, mask_d;
    logic [SEL_WIDTH-1:0]      cur_q, cur_d;
    logic                      aborted_q, aborted_d;
    logic [SEL_WIDTH-1:0]      abort_phase_q, abort_phase_d;

    logic [NUM_PHASES-1:0]     sel_mask;
    logic [SEL_WIDTH:0]        sel_cur;
    logic [SEL_WIDTH-1:0]      nxt_idx;
    logic                      nxt_vld;
    logic                      in_run;

    logic [NUM_PHASES-1:0][ADDR_WIDTH-1:0] addr_arr;
    logic [NUM_PHASES-1:0][DATA_WIDTH-1:0] wdata_arr;

`ifdef PHASE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
    logic            wd_expire;

    // The count of completed WAIT cycles reaches TIMEOUT_CYCLES on this edge.
    assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;
`endif

    // In IDLE search the incoming mask from "before 0"; otherwise search the
    // latched mask above the current phase.
    assign sel_mask = (state_q == S_IDLE) ? phase_mask : mask_q;
    assign sel_cur  = (state_q == S_IDLE) ? '1 : {1'b0, cur_q};

    phase_next_sel #(
        .NUM_PHASES (NUM_PHASES),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_next_sel (
        .mask     (sel_mask),
        .cur      (sel_cur),
        .next_idx (nxt_idx),
        .next_vld (nxt_vld)
    );

    // State and run-context registers; reset abandons any run silently.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            cur_q         <= '0;
            aborted_q     <= 1'b0;
            abort_phase_q <= '0;
`ifdef PHASE_WATCHDOG_EN
            wd_q          <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            cur_q         <= cur_d;
            aborted_q     <= aborted_d;
            abort_phase_q <= abort_phase_d;
`ifdef PHASE_WATCHDOG_EN
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    // Next-state logic; only the current phase's done/abort are observed.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        cur_d         = cur_q;
        aborted_d     = aborted_q;
        abort_phase_d = abort_phase_q;
`ifdef PHASE_WATCHDOG_EN
        wd_d          = wd_q;
        timeout_d     = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    mask_d    = phase_mask;
                    aborted_d = 1'b0;
`ifdef PHASE_WATCHDOG_EN
                    timeout_d = 1'b0;
`endif
                    if (nxt_vld) begin
                        cur_d   = nxt_idx;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef PHASE_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (phase_abort[cur_q]) begin
                    aborted_d     = 1'b1;
                    abort_phase_d = cur_q;
                    state_d       = S_FINISH;
                end else if (phase_done[cur_q]) begin
                    if (nxt_vld) begin
                        cur_d   = nxt_idx;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
`ifdef PHASE_WATCHDOG_EN
                else if (wd_expire) begin
                    aborted_d     = 1'b1;
                    abort_phase_d = cur_q;
                    timeout_d     = 1'b1;
                    state_d       = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign in_run    = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign addr_arr  = phase_addr;
    assign wdata_arr = phase_wdata;

    // Memory port follows the active phase only while a phase is running.
    assign mem_addr  = in_run ? addr_arr[cur_q]  : '0;
    assign mem_wdata = in_run ? wdata_arr[cur_q] : '0;
    assign mem_wr_en = in_run & phase_wr_en[cur_q];

    assign phase_start  = (state_q == S_LAUNCH) ? (NUM_PHASES'(1) << cur_q) : '0;
    assign active_phase = cur_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign aborted      = aborted_q;
    assign abort_phase  = abort_phase_q;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generalised phase sequencer and shared-memory port arbiter for the routing-node datapath.
- Launches up to NUM_PHASES client blocks in fixed index order using start/done handshakes.
- Routes the active client's address, write-enable and write-data onto the single memory port.
- Supports per-run phase masking and early termination by client abort (e.g. forAggregation), replacing hard-wired done-flag muxing.

Parameters:
NUM_PHASES, 8, number of client phases/channels (2..16)
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 16, memory data width
SEL_WIDTH, $clog2(NUM_PHASES), phase index width
TIMEOUT_CYCLES, 4096, watchdog limit per phase (only with PHASE_WATCHDOG_EN)

Ports:
clock  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
en  in  1  run request, sampled in IDLE only
phase_mask  in  NUM_PHASES  phases enabled for this run, latched when en is accepted
phase_start  out  NUM_PHASES  one-cycle start pulse to phase k
phase_done  in  NUM_PHASES  completion from phase k
phase_abort  in  NUM_PHASES  phase k requests termination of the run
phase_addr  in  NUM_PHASES*ADDR_WIDTH  flattened client addresses, phase k at [k*ADDR_WIDTH +: ADDR_WIDTH]
phase_wr_en  in  NUM_PHASES  client write enables
phase_wdata  in  NUM_PHASES*DATA_WIDTH  flattened client write data
mem_addr  out  ADDR_WIDTH  to memory
mem_wr_en  out  1  to memory
mem_wdata  out  DATA_WIDTH  to memory
active_phase  out  SEL_WIDTH  current phase index
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at end of run
aborted  out  1  sticky; last run ended by abort
abort_phase  out  SEL_WIDTH  index that aborted, valid while aborted=1

Behaviour:
- Reset (async, nrst=0):
  - State goes to IDLE.
  - All outputs go to 0, including mem_wr_en, which drops asynchronously.
  - The latched mask is cleared.
  - Reset mid-run abandons the run; no done pulse is issued.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - On a clock edge with en=1, latch phase_mask and clear aborted.
  - If the mask is non-zero, set cur to its lowest set bit and go to LAUNCH.
  - If the mask is zero, go to FINISH.
  - en while busy is ignored (no queuing).
- LAUNCH:
  - phase_start[cur]=1 for exactly this one cycle.
  - Next state is WAIT, unconditionally.
- WAIT:
  - Only phase_done[cur] and phase_abort[cur] are observed; other indices are ignored.
  - abort[cur]=1: set aborted=1 and abort_phase=cur, go to FINISH. Abort wins over a simultaneous done.
  - done[cur]=1 only: cur becomes the next set mask bit above cur and the state goes to LAUNCH. If no such bit exists, go to FINISH.
  - A done/abort asserted during LAUNCH is ignored. Clients must hold done until the sequencer leaves WAIT or until they are next started.
- FINISH: done=1 for one cycle, then IDLE.
- Latency:
  - en accepted at edge E0 → phase_start pulse in the cycle after E0.
  - phase_done sampled at edge Ek → next phase_start in the cycle after Ek.
  - There is no idle gap beyond the single LAUNCH cycle.
- Memory mux:
  - mem_addr=phase_addr[cur] and mem_wdata=phase_wdata[cur] in LAUNCH and WAIT.
  - mem_wr_en=phase_wr_en[cur] gated by (LAUNCH or WAIT).
  - In IDLE and FINISH: mem_addr=0, mem_wdata=0, mem_wr_en=0.
  - Muxing is combinational from registered cur/state.
  - Writes from inactive phases never reach memory.
- active_phase holds cur; its value in IDLE is the last used index (0 after reset).

Optional Feature:
- Macro: PHASE_WATCHDOG_EN.
- Defined:
  - A counter cleared in LAUNCH increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without done/abort, the block behaves as an abort of cur: aborted=1, abort_phase=cur, go to FINISH.
  - An extra output timeout (1 bit, sticky until the next accepted en, reset 0) is set.
- Undefined: no counter and no timeout port; WAIT may last indefinitely.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, LAUNCH=1, WAIT=2, FINISH=3);
  - default WORD_WIDTH=16;
  - the phase index enumeration of the node pipeline (LEARN_COSTS=0 … SELECT_ACTION=7).
- Sub-module phase_next_sel (combinational): given the mask and cur, returns the next set index above cur plus a valid flag. It is also used with cur=-1 for the first phase.

Test Plan:
- Full run: mask=8'hFF, each phase asserts done 3 cycles after its start. Expect 8 start pulses in order 0..7, each 4 cycles apart; done pulse 1 cycle after phase 7 done; aborted=0.
- Sparse mask: mask=8'b1010_0100. Expect starts only on phases 2, 5 and 7; done pulse after phase 7. Mask=0 → done pulse in the cycle after en, with no starts.
- Abort: phase 3 asserts abort and done together. Expect aborted=1, abort_phase=3, no start to phase 4, one done pulse.
- Mux isolation: phase 4 active; phase 6 drives wr_en=1 with addr=16'h0648. Expect mem_wr_en to follow phase 4 only. In IDLE expect mem_wr_en=0 and mem_addr=0.
- Reset mid-run: drop nrst during phase 5 WAIT, asynchronously between edges. Expect immediate mem_wr_en=0, busy=0, no done pulse. A new en then restarts from the lowest mask bit.
- Watchdog (PHASE_WATCHDOG_EN, TIMEOUT_CYCLES=16): phase 1 never answers. Expect timeout=1, aborted=1, abort_phase=1, done pulse 16 cycles after the WAIT entry.
